main_call_initiator: RTL and testbench
======================================

Name: main_call_initiator

Overview:
Caller-side controller for the generated method-call handshake (req / busy / return) used by the HLS-style compute blocks, such as the SumOfProduct-based main method.
- Converts a one-cycle local start strobe into a compliant request to the callee.
- Tracks the callee's busy window, captures the return value when busy falls, and reports done, call latency and timeout.
- Sits between a host sequencer or test harness and one callee instance.

Parameters:
RET_WIDTH, 32, width of callee return value (signed)
CNT_WIDTH, 16, width of latency/timeout counter
TIMEOUT_CYCLES, 1024, max ce-enabled cycles from request to busy fall; 0 disables timeout

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  asynchronous active-low reset
ce  input  1  clock enable; all state frozen when 0
i_start  input  1  start strobe, accepted only in IDLE
o_ready  output  1  1 when in IDLE and able to accept i_start
o_main_req  output  1  request to callee (drives callee i_main_req)
i_main_busy  input  1  callee busy (from callee o_main_busy)
i_main_return  input  RET_WIDTH  callee return value (signed)
o_done  output  1  one ce-cycle pulse: call completed, o_result valid
o_result  output  RET_WIDTH  captured return; holds until next completion
o_timeout  output  1  one ce-cycle pulse: call aborted by timeout
o_error  output  1  sticky timeout flag; cleared by reset or next accepted i_start
o_cycles  output  CNT_WIDTH  ce-cycles from request to completion; saturates at all-ones

Behaviour:
- Reset is asynchronous, active-low.
  - State goes to IDLE.
  - o_main_req, o_done, o_timeout and o_error are 0; o_result and o_cycles are 0; o_ready is 1.
  - Reset mid-call drops o_main_req immediately. The callee is reset by the same reset_n.
- All registers update only on clock edges with ce=1. With ce=0, outputs hold, and pulses are held rather than repeated.
- States: IDLE, REQ, RUN.
- IDLE:
  - o_ready=1. On i_start=1, go to REQ and set o_main_req=1 (registered, visible the next cycle).
  - Load counter with 0 and clear o_error.
- REQ:
  - Hold o_main_req=1 until i_main_busy=1 is sampled.
  - On that edge, set o_main_req=0 and go to RUN. In the callee, busy follows req from its idle state, so this normally takes 1 cycle.
  - o_main_req must be 0 while in RUN. If req were still high when the callee returns to idle, it would re-trigger.
- RUN:
  - On sampling i_main_busy=0, capture o_result<=i_main_return, o_cycles<=counter+1, pulse o_done, and go to IDLE.
  - The return value is stable before busy falls.
- Counter: increments by 1 each ce cycle in REQ and RUN, and saturates.
- Timeout (TIMEOUT_CYCLES>0): when in REQ or RUN and the counter reaches TIMEOUT_CYCLES-1 without completion:
  - Pulse o_timeout and set o_error=1.
  - Set o_main_req=0, load o_cycles with TIMEOUT_CYCLES, and go to IDLE.
  - o_result is unchanged.
- Simultaneous completion and timeout on the same edge: completion wins; o_done fires and o_timeout does not.
- i_start while not IDLE is ignored; there is no queueing.
- Back-to-back starts: i_start may be asserted in the same cycle o_done is high, because o_ready is already 1. A new call begins the next cycle.
- o_done and o_timeout are mutually exclusive and each is high for exactly one ce-enabled cycle.
- Busy already high in IDLE (callee not yet released): i_start is still accepted. REQ then sees busy=1 at once and moves to RUN; this is documented caller misuse.
- Return values are treated as signed and passed through unmodified; no width conversion.

Test Plan:
- Reset, then one i_start pulse to a callee computing 10*20+30 + 40*50+60 -> o_main_req high for exactly 1 cycle before busy seen; o_done pulse once; o_result=2290; o_error=0.
- Callee model with busy delayed 3 cycles after req and held 20 cycles -> o_main_req stays high until busy=1, then 0; o_cycles=24; o_result matches the model value 0xFFFF_FF85 (-123).
- TIMEOUT_CYCLES=8, callee never asserts busy -> o_timeout pulse after 8 cycles; o_error=1; o_main_req=0; o_cycles=8; o_result keeps its prior value; next i_start clears o_error.
- ce toggled 0/1 every other cycle during a call -> same o_result and o_cycles as the ce=1 run; o_done observed during exactly one ce=1 edge.
- i_start held high continuously for 3 calls -> exactly 3 o_done pulses, 3 captured results, and o_main_req never high while busy=1 in RUN.
- reset_n asserted asynchronously mid-RUN -> o_main_req, o_done and o_error go to 0 without a clock edge; state is IDLE; o_ready=1.

Source files
------------

// File: rtl/main_call_initiator.sv
// rtl/main_call_initiator.sv - caller-side req/busy/return handshake controller
// Issues a request to one callee, tracks its busy window, captures the return value, reports latency/timeout.
module main_call_initiator #(
  parameter int RET_WIDTH      = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        ce,
  input  logic                        i_start,
  output logic                        o_ready,
  output logic                        o_main_req,
  input  logic                        i_main_busy,
  input  logic signed [RET_WIDTH-1:0] i_main_return,
  output logic                        o_done,
  output logic signed [RET_WIDTH-1:0] o_result,
  output logic                        o_timeout,
  output logic                        o_error,
  output logic        [CNT_WIDTH-1:0] o_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam bit                   TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LOAD = CNT_WIDTH'(TIMEOUT_CYCLES);

  state_t                      r_state;
  logic                        r_req;
  logic                        r_done;
  logic                        r_timeout;
  logic                        r_error;
  logic signed [RET_WIDTH-1:0] r_result;
  logic        [CNT_WIDTH-1:0] r_cycles;
  logic        [CNT_WIDTH-1:0] r_cnt;

  state_t                      w_state;
  logic                        w_req;
  logic                        w_done;
  logic                        w_timeout;
  logic                        w_error;
  logic signed [RET_WIDTH-1:0] w_result;
  logic        [CNT_WIDTH-1:0] w_cycles;
  logic        [CNT_WIDTH-1:0] w_cnt;
  logic        [CNT_WIDTH-1:0] w_cnt_inc;
  logic                        w_to_hit;

  // Saturating increment; the same value doubles as the completion latency.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_to_hit  = TO_EN && (r_cnt == TO_LAST);

  always_comb begin
    w_state   = r_state;
    w_req     = r_req;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    w_error   = r_error;
    w_result  = r_result;
    w_cycles  = r_cycles;
    w_cnt     = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state = ST_REQ;
          w_req   = 1'b1;
          w_cnt   = '0;
          w_error = 1'b0;
        end
      end

      ST_REQ: begin
        w_cnt = w_cnt_inc;
        if (w_to_hit) begin
          w_state   = ST_IDLE;
          w_req     = 1'b0;
          w_timeout = 1'b1;
          w_error   = 1'b1;
          w_cycles  = TO_LOAD;
        end else if (i_main_busy) begin
          // Drop req right away so the callee cannot re-trigger when it goes idle.
          w_state = ST_RUN;
          w_req   = 1'b0;
        end
      end

      ST_RUN: begin
        w_cnt = w_cnt_inc;
        w_req = 1'b0;
        if (!i_main_busy) begin
          // Completion takes priority over a timeout landing on the same edge.
          w_state  = ST_IDLE;
          w_done   = 1'b1;
          w_result = i_main_return;
          w_cycles = w_cnt_inc;
        end else if (w_to_hit) begin
          w_state   = ST_IDLE;
          w_timeout = 1'b1;
          w_error   = 1'b1;
          w_cycles  = TO_LOAD;
        end
      end

      default: begin
        w_state = ST_IDLE;
        w_req   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_error   <= 1'b0;
      r_result  <= '0;
      r_cycles  <= '0;
      r_cnt     <= '0;
    end else if (ce) begin
      r_state   <= w_state;
      r_req     <= w_req;
      r_done    <= w_done;
      r_timeout <= w_timeout;
      r_error   <= w_error;
      r_result  <= w_result;
      r_cycles  <= w_cycles;
      r_cnt     <= w_cnt;
    end
  end

  assign o_ready    = (r_state == ST_IDLE);
  assign o_main_req = r_req;
  assign o_done     = r_done;
  assign o_result   = r_result;
  assign o_timeout  = r_timeout;
  assign o_error    = r_error;
  assign o_cycles   = r_cycles;

endmodule

// File: tb/tb_main_call_initiator.sv
// tb/tb_main_call_initiator.sv - directed bench for main_call_initiator
// Instance A uses the default timeout, instance B a timeout of 8; both share one callee model.
module tb_main_call_initiator;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;

  logic        ready_a, req_a, done_a, to_a, err_a;
  logic [31:0] result_a;
  logic [15:0] cyc_a;
  logic        ready_b, req_b, done_b, to_b, err_b;
  logic [31:0] result_b;
  logic [15:0] cyc_b;

  // Callee model configuration
  bit          cfg_sel = 1'b0;
  bit          cfg_never = 1'b0;
  bit          cfg_inc = 1'b0;
  int          cfg_delay = 1;
  int          cfg_hold = 5;
  logic [31:0] cfg_ret = '0;
  bit          ce_toggle = 1'b0;

  logic        m_busy;
  logic [31:0] m_ret;
  int          m_cnt;
  int          m_hold;
  int          m_calls;
  logic        w_req_sel;

  int n_checks = 0;
  int n_errors = 0;
  int ev_done_a = 0, ev_rnb_a = 0, ev_rb_a = 0, ev_done_b = 0, ev_to_b = 0;

  always #5 clock = ~clock;

  main_call_initiator dut_a (
    .clock(clock), .reset_n(reset_n), .ce(ce), .i_start(start_a),
    .o_ready(ready_a), .o_main_req(req_a), .i_main_busy(m_busy), .i_main_return(m_ret),
    .o_done(done_a), .o_result(result_a), .o_timeout(to_a), .o_error(err_a), .o_cycles(cyc_a)
  );

  main_call_initiator #(.TIMEOUT_CYCLES(8)) dut_b (
    .clock(clock), .reset_n(reset_n), .ce(ce), .i_start(start_b),
    .o_ready(ready_b), .o_main_req(req_b), .i_main_busy(m_busy), .i_main_return(m_ret),
    .o_done(done_b), .o_result(result_b), .o_timeout(to_b), .o_error(err_b), .o_cycles(cyc_b)
  );

  assign w_req_sel = cfg_sel ? req_b : req_a;

  // Callee: busy rises after cfg_delay sampled requests, stays high for cfg_hold edges.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy  <= 1'b0;
      m_ret   <= '0;
      m_cnt   <= 0;
      m_hold  <= 0;
      m_calls <= 0;
    end else if (ce) begin
      if (m_busy) begin
        if (m_hold <= 1) m_busy <= 1'b0;
        else m_hold <= m_hold - 1;
      end else if (w_req_sel && !cfg_never) begin
        if (m_cnt + 1 >= cfg_delay) begin
          m_busy  <= 1'b1;
          m_hold  <= cfg_hold;
          m_cnt   <= 0;
          m_ret   <= cfg_inc ? cfg_ret + 32'(m_calls) : cfg_ret;
          m_calls <= m_calls + 1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else begin
        m_cnt <= 0;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && ce) begin
      if (done_a) ev_done_a++;
      if (req_a && !m_busy) ev_rnb_a++;
      if (req_a && m_busy) ev_rb_a++;
      if (done_b) ev_done_b++;
      if (to_b) ev_to_b++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (ce_toggle) ce = ~ce;
  endtask

  task automatic start_call(input bit sel);
    if (sel) start_b = 1'b1;
    else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_ready(input bit sel, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(sel ? ready_b : ready_a) && n < budget);
    if (!(sel ? ready_b : ready_a)) check("wait_ready", 64'd0, 64'd1);
  endtask

  int          n, d_done, d_rnb, d_rb, d_to, c0, got;
  logic [31:0] res [3];

  initial begin
    repeat (3) tick();
    // Reset state
    check("rst_ready", ready_a, 1);
    check("rst_req", req_a, 0);
    check("rst_done", done_a, 0);
    check("rst_timeout", to_a, 0);
    check("rst_error", err_a, 0);
    check("rst_result", result_a, 0);
    check("rst_cycles", cyc_a, 0);
    reset_n = 1'b1;
    tick();
    check("rst_ready_b", ready_b, 1);

    // Single call: 10*20+30 + 40*50+60
    cfg_sel = 0; cfg_delay = 1; cfg_hold = 5; cfg_ret = 32'd2290;
    d_done = ev_done_a; d_rnb = ev_rnb_a; d_rb = ev_rb_a;
    start_call(0);
    check("t1_req_on", req_a, 1);
    check("t1_ready_off", ready_a, 0);
    wait_ready(0, 100, n);
    check("t1_done", done_a, 1);
    check("t1_result", result_a, 32'd2290);
    check("t1_cycles", cyc_a, 7);
    check("t1_error", err_a, 0);
    check("t1_req_off", req_a, 0);
    tick();
    check("t1_done_clr", done_a, 0);
    check("t1_done_n", 64'(ev_done_a - d_done), 1);
    check("t1_req_nobusy", 64'(ev_rnb_a - d_rnb), 1);
    check("t1_req_busy", 64'(ev_rb_a - d_rb), 1);

    // Delayed busy, long hold, negative return
    cfg_delay = 3; cfg_hold = 20; cfg_ret = 32'hFFFF_FF85;
    d_rnb = ev_rnb_a; d_rb = ev_rb_a;
    start_call(0);
    wait_ready(0, 100, n);
    check("t2_done", done_a, 1);
    check("t2_result", result_a, 32'hFFFF_FF85);
    check("t2_cycles", cyc_a, 24);
    check("t2_req_nobusy", 64'(ev_rnb_a - d_rnb), 3);
    check("t2_req_busy", 64'(ev_rb_a - d_rb), 1);

    // Timeout on instance B after one good call
    cfg_sel = 1; cfg_delay = 1; cfg_hold = 2; cfg_ret = 32'd77;
    start_call(1);
    wait_ready(1, 50, n);
    check("t3_pre_result", result_b, 77);
    check("t3_pre_cycles", cyc_b, 4);
    cfg_never = 1;
    d_to = ev_to_b;
    start_call(1);
    wait_ready(1, 50, n);
    check("t3_to_latency", 64'(n), 8);
    check("t3_timeout", to_b, 1);
    check("t3_done", done_b, 0);
    check("t3_error", err_b, 1);
    check("t3_req", req_b, 0);
    check("t3_cycles", cyc_b, 8);
    check("t3_result_kept", result_b, 77);
    tick();
    check("t3_timeout_clr", to_b, 0);
    check("t3_error_sticky", err_b, 1);
    check("t3_to_n", 64'(ev_to_b - d_to), 1);
    cfg_never = 0; cfg_ret = 32'd5;
    start_call(1);
    check("t3_error_cleared", err_b, 0);
    wait_ready(1, 50, n);
    check("t3_post_result", result_b, 5);
    check("t3_post_done", done_b, 1);

    // ce toggling every other cycle
    tick();
    cfg_sel = 0; cfg_delay = 3; cfg_hold = 20; cfg_ret = 32'hFFFF_FF85;
    d_done = ev_done_a;
    ce_toggle = 1; ce = 1;
    start_a = 1;
    tick();
    tick();
    start_a = 0;
    wait_ready(0, 200, n);
    check("t4_result", result_a, 32'hFFFF_FF85);
    check("t4_cycles", cyc_a, 24);
    repeat (4) tick();
    ce_toggle = 0; ce = 1;
    tick();
    check("t4_done_n", 64'(ev_done_a - d_done), 1);
    check("t4_done_clr", done_a, 0);

    // i_start held for three back-to-back calls
    cfg_delay = 1; cfg_hold = 3; cfg_ret = 32'h100; cfg_inc = 1;
    c0 = m_calls;
    d_done = ev_done_a; d_rb = ev_rb_a;
    got = 0; n = 0;
    start_a = 1;
    while (got < 3 && n < 200) begin
      tick();
      n++;
      if (done_a) begin
        res[got] = result_a;
        got++;
        if (got == 3) start_a = 0;
      end
    end
    start_a = 0;
    check("t5_got", 64'(got), 3);
    for (int i = 0; i < 3; i++) check("t5_result", res[i], 32'h100 + 32'(c0 + i));
    check("t5_cycles", cyc_a, 5);
    tick();
    check("t5_done_n", 64'(ev_done_a - d_done), 3);
    check("t5_req_busy", 64'(ev_rb_a - d_rb), 3);
    check("t5_idle", ready_a, 1);
    cfg_inc = 0;

    // Async reset mid-RUN, with B holding a sticky error
    cfg_sel = 1; cfg_never = 1;
    start_call(1);
    wait_ready(1, 50, n);
    check("t6_err_b_set", err_b, 1);
    tick();
    cfg_sel = 0; cfg_never = 0; cfg_delay = 1; cfg_hold = 20; cfg_ret = 32'd99;
    start_call(0);
    repeat (4) tick();
    check("t6_in_run", ready_a, 0);
    check("t6_busy", m_busy, 1);
    #1 reset_n = 1'b0;
    #1;
    check("t6_req", req_a, 0);
    check("t6_ready", ready_a, 1);
    check("t6_done", done_a, 0);
    check("t6_err_b", err_b, 0);
    check("t6_result", result_a, 0);
    check("t6_cycles", cyc_a, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("t6_ready_after", ready_a, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
